vx_icache_lite: RTL and testbench

//  Read-only, direct-mapped, blocking instruction cache; the responder end of the fetch unit's icache request bus.

---
 rtl/vx_icache_lite.sv | 155 +++++++++++++++
 tb/tb_vx_icache_lite.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_icache_lite.sv
// rtl/vx_icache_lite.sv - read-only direct-mapped blocking instruction cache
// One request under lookup in S1, one line refill outstanding, responses in request order.
module vx_icache_lite #(
   parameter int ADDR_WIDTH = 30,
   parameter int TAG_WIDTH  = 12,
   parameter int NUM_LINES  = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      req_valid,
   output logic                                      req_ready,
   input  logic [ADDR_WIDTH-1:0]                     req_addr,
   input  logic [TAG_WIDTH-1:0]                      req_tag,
   output logic                                      rsp_valid,
   input  logic                                      rsp_ready,
   output logic [31:0]                               rsp_data,
   output logic [TAG_WIDTH-1:0]                      rsp_tag,
   output logic                                      mem_req_valid,
   input  logic                                      mem_req_ready,
   output logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0]  mem_req_addr,
   input  logic                                      mem_rsp_valid,
   input  logic [32*LINE_WORDS-1:0]                  mem_rsp_data,
   output logic                                      mem_rsp_ready,
   input  logic                                      flush,
   output logic                                      flush_done
);
   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int CTAG_W = ADDR_WIDTH - OFF_W - IDX_W;
   localparam int LINE_W = 32 * LINE_WORDS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MISS_REQ,
      S_MISS_WAIT,
      S_REPLAY
   } state_t;

   state_t                 state_q, state_d;
   logic                   s1_valid_q, s1_valid_d;
   logic [ADDR_WIDTH-1:0]  s1_addr_q, s1_addr_d;
   logic [TAG_WIDTH-1:0]   s1_tag_q, s1_tag_d;
   logic [NUM_LINES-1:0]   valid_q, valid_d;

   logic [CTAG_W-1:0]      ctag_mem [NUM_LINES];
   logic [LINE_W-1:0]      data_mem [NUM_LINES];
   logic [CTAG_W-1:0]      rd_ctag_q;
   logic [LINE_W-1:0]      rd_line_q;

   logic                   rd_en;
   logic [IDX_W-1:0]       rd_idx;
   logic                   fill_en;
   logic                   hit;

   logic [IDX_W-1:0]       s1_idx;
   logic [OFF_W-1:0]       s1_off;
   logic [CTAG_W-1:0]      s1_ctag;

   assign s1_off  = s1_addr_q[OFF_W-1:0];
   assign s1_idx  = s1_addr_q[OFF_W +: IDX_W];
   assign s1_ctag = s1_addr_q[ADDR_WIDTH-1 -: CTAG_W];

   // RAM outputs are only trusted in IDLE: they were read at accept or in REPLAY.
   assign hit = s1_valid_q && valid_q[s1_idx] && (rd_ctag_q == s1_ctag);

   assign rsp_data      = rd_line_q[32*s1_off +: 32];
   assign rsp_tag       = s1_tag_q;
   assign mem_req_addr  = s1_addr_q[ADDR_WIDTH-1:OFF_W];
   assign mem_rsp_ready = 1'b1;

   always_comb begin
      state_d       = state_q;
      s1_valid_d    = s1_valid_q;
      s1_addr_d     = s1_addr_q;
      s1_tag_d      = s1_tag_q;
      valid_d       = valid_q;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      mem_req_valid = 1'b0;
      flush_done    = 1'b0;
      rd_en         = 1'b0;
      rd_idx        = s1_idx;
      fill_en       = 1'b0;
      case (state_q)
         S_IDLE: begin
            rsp_valid = hit;
            req_ready = !flush && (!s1_valid_q || (hit && rsp_ready));
            if (flush && !s1_valid_q) begin
               valid_d    = '0;
               flush_done = 1'b1;
            end else if (s1_valid_q && !hit) begin
               state_d = S_MISS_REQ;
            end else if (hit && rsp_ready) begin
               s1_valid_d = 1'b0;
            end
            if (req_valid && req_ready) begin
               s1_valid_d = 1'b1;
               s1_addr_d  = req_addr;
               s1_tag_d   = req_tag;
               rd_en      = 1'b1;
               rd_idx     = req_addr[OFF_W +: IDX_W];
            end
         end
         S_MISS_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_d = S_MISS_WAIT;
            end
         end
         S_MISS_WAIT: begin
            if (mem_rsp_valid) begin
               fill_en         = 1'b1;
               valid_d[s1_idx] = 1'b1;
               state_d         = S_REPLAY;
            end
         end
         S_REPLAY: begin
            rd_en   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s1_tag_q   <= '0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         s1_valid_q <= s1_valid_d;
         s1_addr_q  <= s1_addr_d;
         s1_tag_q   <= s1_tag_d;
         valid_q    <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_en && !reset) begin
         ctag_mem[s1_idx] <= s1_ctag;
         data_mem[s1_idx] <= mem_rsp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_ctag_q <= ctag_mem[rd_idx];
         rd_line_q <= data_mem[rd_idx];
      end
   end
endmodule

// File: tb/tb_vx_icache_lite.sv
// tb/tb_vx_icache_lite.sv - bench for vx_icache_lite
// Scoreboard plus line-residency model; directed scenarios then random traffic.
module tb_vx_icache_lite;
   localparam int AW    = 30;
   localparam int TW    = 12;
   localparam int NL    = 64;
   localparam int LW    = 4;
   localparam int OFF_W = 2;
   localparam int IDX_W = 6;
   localparam int CT_W  = AW - OFF_W - IDX_W;
   localparam int MAW   = AW - OFF_W;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [AW-1:0]   req_addr = '0;
   logic [TW-1:0]   req_tag = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b1;
   logic [31:0]     rsp_data;
   logic [TW-1:0]   rsp_tag;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [MAW-1:0]  mem_req_addr;
   logic            mem_rsp_valid;
   logic [32*LW-1:0] mem_rsp_data;
   logic            mem_rsp_ready;
   logic            flush = 1'b0;
   logic            flush_done;

   vx_icache_lite #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .NUM_LINES(NL), .LINE_WORDS(LW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
      .flush(flush), .flush_done(flush_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0]   d;
      logic [TW-1:0] t;
   } exp_t;

   exp_t           exp_q[$];
   logic [MAW-1:0] miss_q[$];
   bit             mv[NL];
   logic [CT_W-1:0] mct[NL];
   int             pending = 0;
   bit             chk_lat = 0, chk_hit = 0, acc_last = 0;
   bit             hold = 0, mreq_hold = 0;
   logic [31:0]    hold_d;
   logic [TW-1:0]  hold_t;
   logic [MAW-1:0] mreq_hold_a;
   bit             mem_out = 0, mem_auto = 1, inject_beat = 0;
   logic [MAW-1:0] mem_line;
   int             mem_dly = 0;
   int             rsp_count = 0, mreq_count = 0, fd_count = 0;
   int             last_rsp_cyc = 0, mem_rsp_cyc = 0;
   logic [31:0]    last_rsp_d;
   logic [TW-1:0]  last_rsp_t;
   logic [MAW-1:0] last_mreq_a;

   // Backing memory contents: a fixed function of the word address.
   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return ({2'b00, a} * 32'h0001_0003) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [32*LW-1:0] line_data(input logic [MAW-1:0] la);
      logic [32*LW-1:0] d;
      for (int k = 0; k < LW; k++) d[32*k +: 32] = mem_word(AW'(la * LW + k));
      return d;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      int ix, ct, of;
      case ($urandom_range(0, 3))
         0: ix = 0;
         1: ix = 1;
         2: ix = 2;
         default: ix = NL - 1;
      endcase
      ct = $urandom_range(0, 2);
      of = $urandom_range(0, LW - 1);
      return AW'(ct * NL * LW + ix * LW + of);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      bit exp_fd, exp_rr, h;
      exp_t e;
      int ix;
      if (reset) begin
         exp_q.delete();
         miss_q.delete();
         for (int i = 0; i < NL; i++) mv[i] = 0;
         pending = 0; chk_lat = 0; acc_last = 0; hold = 0; mreq_hold = 0; mem_out = 0;
      end else begin
         if (chk_lat) chk(chk_hit ? "hit_latency" : "miss_no_rsp", rsp_valid, chk_hit);
         chk_lat = 0;
         chk("mem_rsp_ready", mem_rsp_ready, 1);
         exp_fd = flush && (pending == 0);
         chk("flush_done", flush_done, exp_fd);
         if (flush) exp_rr = 0;
         else if (pending == 0) exp_rr = 1;
         else exp_rr = (pending == 1) && rsp_valid && rsp_ready;
         chk("req_ready", req_ready, exp_rr);
         if (hold) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, hold_d);
            chk("hold_tag", rsp_tag, hold_t);
         end
         hold = 0;
         if (rsp_valid) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else if (rsp_ready) begin
               e = exp_q.pop_front();
               chk("rsp_data", rsp_data, e.d);
               chk("rsp_tag", rsp_tag, e.t);
               pending--; rsp_count++;
               last_rsp_cyc = cyc; last_rsp_d = rsp_data; last_rsp_t = rsp_tag;
            end else begin
               hold = 1; hold_d = rsp_data; hold_t = rsp_tag;
            end
         end
         if (mem_rsp_valid && mem_out) begin
            mem_out = 0;
            mem_rsp_cyc = cyc;
         end
         if (mreq_hold) begin
            chk("mreq_hold_valid", mem_req_valid, 1);
            chk("mreq_hold_addr", mem_req_addr, mreq_hold_a);
         end
         mreq_hold = mem_req_valid && !mem_req_ready;
         mreq_hold_a = mem_req_addr;
         if (mem_req_valid && mem_req_ready) begin
            if (miss_q.size() == 0) chk("mreq_unexpected", 1, 0);
            else chk("mreq_addr", mem_req_addr, miss_q.pop_front());
            mem_out = 1; mem_line = mem_req_addr; mem_dly = $urandom_range(0, 4);
            mreq_count++; last_mreq_a = mem_req_addr;
         end
         if (flush_done) fd_count++;
         if (exp_fd) for (int i = 0; i < NL; i++) mv[i] = 0;
         acc_last = req_valid && req_ready;
         if (acc_last) begin
            ix = int'(req_addr[OFF_W +: IDX_W]);
            h = mv[ix] && (mct[ix] == req_addr[AW-1 -: CT_W]);
            if (!h) begin
               miss_q.push_back(req_addr[AW-1:OFF_W]);
               mv[ix] = 1;
               mct[ix] = req_addr[AW-1 -: CT_W];
            end
            e.d = mem_word(req_addr); e.t = req_tag;
            exp_q.push_back(e);
            pending++; chk_lat = 1; chk_hit = h;
         end
      end
   end

   // Lower memory: answers the outstanding refill after a short random delay,
   // and otherwise occasionally fires stray beats that the cache must ignore.
   initial begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      forever begin
         @(posedge clk); #2;
         mem_rsp_valid = 1'b0;
         mem_req_ready = ($urandom_range(0, 3) != 0);
         if (inject_beat || (!mem_out && $urandom_range(0, 15) == 0)) begin
            mem_rsp_valid = 1'b1;
            for (int k = 0; k < LW; k++) mem_rsp_data[32*k +: 32] = $urandom();
         end else if (mem_out && mem_auto) begin
            if (mem_dly == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = line_data(mem_line);
            end else mem_dly--;
         end
      end
   end

   task automatic do_req(input logic [AW-1:0] a, input logic [TW-1:0] t);
      int n = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = a; req_tag = t;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("req_accept_timeout", 1, 0);
   endtask

   task automatic idle_req();
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((pending != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("drain_timeout", 1, 0);
   endtask

   initial begin
      int m0, r0, f0, c0, c1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", req_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_mem_req_valid", mem_req_valid, 0);
      chk("reset_flush_done", flush_done, 0);

      // cold miss
      m0 = mreq_count;
      do_req(30'h40, 12'h5); idle_req(); wait_idle();
      chk("cold_mreq_count", mreq_count - m0, 1);
      chk("cold_mreq_addr", last_mreq_a, 28'h10);
      chk("cold_rsp_data", last_rsp_d, 32'h5A1A_00C0);
      chk("cold_rsp_tag", last_rsp_t, 12'h5);
      chk("cold_rsp_after_fill", (last_rsp_cyc - mem_rsp_cyc) >= 2, 1);

      // back-to-back hits
      r0 = rsp_count; m0 = mreq_count;
      for (int i = 0; i < 4; i++) begin
         do_req(30'h40 + 30'(i), 12'(16 + i));
         if (i == 0) c0 = cyc;
         c1 = cyc;
      end
      idle_req(); wait_idle();
      chk("stream_span", c1 - c0, 3);
      chk("stream_rsps", rsp_count - r0, 4);
      chk("stream_no_miss", mreq_count - m0, 0);
      chk("stream_last_data", last_rsp_d, 32'h5A19_00C9);
      chk("stream_last_tag", last_rsp_t, 12'h13);

      // response backpressure
      r0 = rsp_count;
      rsp_ready = 1'b0;
      do_req(30'h41, 12'h77); idle_req();
      repeat (5) @(negedge clk);
      chk("bp_held_no_rsp", rsp_count - r0, 0);
      @(posedge clk); #1 rsp_ready = 1'b1;
      wait_idle();
      chk("bp_one_rsp", rsp_count - r0, 1);

      // conflict miss
      m0 = mreq_count;
      do_req(30'h40 + 30'(4 * NL), 12'h9); idle_req(); wait_idle();
      do_req(30'h40, 12'hA); idle_req(); wait_idle();
      chk("conflict_misses", mreq_count - m0, 2);

      // flush
      f0 = fd_count; m0 = mreq_count;
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_pulses", fd_count - f0, 1);
      do_req(30'h40, 12'hB); idle_req(); wait_idle();
      chk("flush_then_miss", mreq_count - m0, 1);

      // reset while waiting on the refill, then a late beat
      mem_auto = 0;
      r0 = rsp_count;
      do_req(30'h84, 12'h7); idle_req();
      begin
         int n = 0;
         while (!mem_out && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("reset_test_mreq_seen", mem_out, 1);
      end
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; inject_beat = 1'b1;
      @(posedge clk); #1 inject_beat = 1'b0; mem_auto = 1;
      repeat (4) @(negedge clk);
      chk("reset_discard_no_rsp", rsp_count - r0, 0);
      m0 = mreq_count;
      do_req(30'h84, 12'h8); idle_req(); wait_idle();
      chk("reset_then_miss", mreq_count - m0, 1);
      chk("reset_then_tag", last_rsp_t, 12'h8);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rsp_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         if (!req_valid || acc_last) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_addr  = rand_addr();
            req_tag   = TW'($urandom());
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
      wait_idle();
      chk("final_drain", pending, 0);
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
